clock_divider_gf: RTL and testbench



---
 rtl/clock_divider_gf.sv | 140 ++++++++++++++
 tb/tb_clock_divider_gf.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_gf.sv
// Glitch-free integer clock divider: ratio/enable are sampled only at divided-period
// boundaries, with a period-start tick and status outputs for clock gating and monitoring.
module clock_divider_gf #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 i_ref_clk,
  input  logic                 i_rst,
  input  logic                 i_clk_en,
  input  logic [DIV_WIDTH-1:0] i_div_ratio,
  output logic                 o_div_clk,
  output logic                 o_period_tick,
  output logic                 o_active,
  output logic [DIV_WIDTH-1:0] o_active_ratio
);

  typedef enum logic {
    ST_BYPASS = 1'b0,
    ST_DIVIDE = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_ratio;
  logic                 r_div_q;
  logic                 r_tick;

  logic [DIV_WIDTH-1:0] w_cnt_nxt;
  logic [DIV_WIDTH-1:0] w_ratio_nxt;
  logic                 w_div_q_nxt;
  logic                 w_tick_nxt;
  logic                 w_cfg_valid;
  logic                 w_boundary;
  logic [DIV_WIDTH-1:0] w_cnt_inc;
  logic [DIV_WIDTH-1:0] w_last;
  logic [DIV_WIDTH-1:0] w_high_len;

  // High phase is ceil(N/2), so odd ratios spend the extra ref cycle high.
  function automatic logic [DIV_WIDTH-1:0] f_high_len(input logic [DIV_WIDTH-1:0] n);
    return n - (n >> 1);
  endfunction

  function automatic logic f_cfg_valid(input logic en, input logic [DIV_WIDTH-1:0] n);
    return en && (n >= DIV_WIDTH'(2));
  endfunction

  always_comb begin
    w_cfg_valid = f_cfg_valid(i_clk_en, i_div_ratio);
    w_last      = r_ratio - DIV_WIDTH'(1);
    w_boundary  = (r_cnt == w_last);
    w_cnt_inc   = r_cnt + DIV_WIDTH'(1);
    w_high_len  = f_high_len(r_ratio);
  end

  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_BYPASS;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BYPASS: begin
        if (w_cfg_valid) w_state_nxt = ST_DIVIDE;
      end
      ST_DIVIDE: begin
        if (w_boundary && !w_cfg_valid) w_state_nxt = ST_BYPASS;
      end
      default: w_state_nxt = ST_BYPASS;
    endcase
  end

  // Configuration is only consulted on entry from bypass or at the last count of a period.
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_ratio_nxt = r_ratio;
    w_div_q_nxt = r_div_q;
    w_tick_nxt  = 1'b0;
    case (r_state)
      ST_BYPASS: begin
        w_cnt_nxt   = '0;
        if (w_cfg_valid) begin
          w_ratio_nxt = i_div_ratio;
          w_div_q_nxt = 1'b1;
          w_tick_nxt  = 1'b1;
        end else begin
          w_ratio_nxt = '0;
          w_div_q_nxt = 1'b0;
        end
      end
      ST_DIVIDE: begin
        if (!w_boundary) begin
          w_cnt_nxt   = w_cnt_inc;
          w_div_q_nxt = (w_cnt_inc < w_high_len);
        end else if (w_cfg_valid) begin
          w_cnt_nxt   = '0;
          w_ratio_nxt = i_div_ratio;
          w_div_q_nxt = 1'b1;
          w_tick_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = '0;
          w_ratio_nxt = '0;
          w_div_q_nxt = 1'b0;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_ratio_nxt = '0;
        w_div_q_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_ratio <= '0;
      r_div_q <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_ratio <= w_ratio_nxt;
      r_div_q <= w_div_q_nxt;
      r_tick  <= w_tick_nxt;
    end
  end

  // Handover is safe both ways: bypass->divide happens while i_ref_clk and div_q are
  // both high, divide->bypass happens after the low phase, while div_q is already low.
  always_comb begin
    o_div_clk      = (r_state == ST_DIVIDE) ? r_div_q : i_ref_clk;
    o_period_tick  = r_tick;
    o_active       = (r_state == ST_DIVIDE);
    o_active_ratio = r_ratio;
  end

endmodule

// File: tb/tb_clock_divider_gf.sv
// Bench for clock_divider_gf: directed and random ratio/enable sequences checked cycle by
// cycle against a queue-of-phases period model, plus a 12-bit instance at ratio 4095.
module tb_clock_divider_gf;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  ratio;
  logic        div_clk;
  logic        tick;
  logic        active;
  logic [7:0]  act_ratio;

  logic        rst_w;
  logic        en_w;
  logic [11:0] ratio_w;
  logic        div_clk_w;
  logic        tick_w;
  logic        active_w;
  logic [11:0] act_ratio_w;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  clock_divider_gf #(.DIV_WIDTH(8)) u_dut (
    .i_ref_clk      (clk),
    .i_rst          (rst),
    .i_clk_en       (en),
    .i_div_ratio    (ratio),
    .o_div_clk      (div_clk),
    .o_period_tick  (tick),
    .o_active       (active),
    .o_active_ratio (act_ratio)
  );

  clock_divider_gf #(.DIV_WIDTH(12)) u_dut_w (
    .i_ref_clk      (clk),
    .i_rst          (rst_w),
    .i_clk_en       (en_w),
    .i_div_ratio    (ratio_w),
    .o_div_clk      (div_clk_w),
    .o_period_tick  (tick_w),
    .o_active       (active_w),
    .o_active_ratio (act_ratio_w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: each divided period is a queue of per-cycle phases (high/low, tick).
  typedef struct {
    bit hi;
    bit tk;
  } ph_t;

  ph_t q[$];
  ph_t cur;
  bit  m_active;
  int  m_n;

  function automatic void model_reset();
    q.delete();
    m_active = 1'b0;
    m_n      = 0;
    cur.hi   = 1'b0;
    cur.tk   = 1'b0;
  endfunction

  function automatic void load_period(int n);
    ph_t p;
    q.delete();
    for (int i = 0; i < n; i++) begin
      p.hi = (i < (n + 1) / 2);
      p.tk = (i == 0);
      q.push_back(p);
    end
    m_n      = n;
    m_active = 1'b1;
    cur      = q.pop_front();
  endfunction

  function automatic void model_edge();
    bit valid;
    valid = en && (int'(ratio) >= 2);
    if (rst)                model_reset();
    else if (!m_active)     begin if (valid) load_period(int'(ratio)); end
    else if (q.size() != 0) cur = q.pop_front();
    else if (valid)         load_period(int'(ratio));
    else                    model_reset();
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #2;
    chk("tick",       tick,      m_active ? cur.tk : 1'b0);
    chk("active",     active,    m_active);
    chk("act_ratio",  act_ratio, m_n);
    chk("div_clk_hi", div_clk,   m_active ? cur.hi : 1'b1);
    @(negedge clk);
    #2;
    chk("div_clk_lo", div_clk,   m_active ? cur.hi : 1'b0);
  endtask

  task automatic run(input bit e, input int r, input int n);
    en    = e;
    ratio = 8'(r);
    for (int i = 0; i < n; i++) step();
  endtask

  int bad_shape;
  int bad_tick;

  initial begin
    rst     = 1'b1;
    en      = 1'b1;
    ratio   = 8'd0;
    rst_w   = 1'b1;
    en_w    = 1'b1;
    ratio_w = 12'd4095;
    model_reset();

    // Reset held two cycles: output mirrors the reference clock.
    step();
    step();
    chk("w_rst_active", active_w,    1'b0);
    chk("w_rst_ratio",  act_ratio_w, 12'd0);
    rst = 1'b0;

    run(1'b1, 0,   5);
    run(1'b1, 4,   16);
    run(1'b1, 7,   21);
    run(1'b1, 255, 520);
    run(1'b0, 0,   300);

    // Mid-period change 6->3 while the counter sits at 2.
    run(1'b1, 6, 3);
    run(1'b1, 3, 12);

    // Enable drop mid-period at ratio 5, then re-enable at ratio 2.
    run(1'b1, 5, 7);
    run(1'b0, 5, 8);
    run(1'b1, 2, 6);
    run(1'b0, 2, 10);

    // Asynchronous reset in the high phase of a ratio-8 period.
    run(1'b1, 8, 3);
    chk("pre_rst_high", div_clk, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_active", active,    1'b0);
    chk("arst_ratio",  act_ratio, 8'd0);
    chk("arst_tick",   tick,      1'b0);
    chk("arst_divclk", div_clk,   1'b0);
    step();
    step();
    rst = 1'b0;
    run(1'b1, 8, 20);

    for (int ph = 0; ph < 60; ph++) begin
      bit e;
      int r;
      e = ($urandom % 6) != 0;
      r = (($urandom % 8) == 0) ? int'($urandom % 2) : int'($urandom_range(2, 12));
      run(e, r, int'($urandom_range(1, 25)));
    end

    // Wide instance: two full periods at ratio 4095.
    rst_w     = 1'b0;
    bad_shape = 0;
    bad_tick  = 0;
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 4095; c++) begin
        @(posedge clk);
        #2;
        if (div_clk_w !== (c < 2048)) bad_shape++;
        if (tick_w !== (c == 0)) bad_tick++;
      end
    end
    chk("w_shape_errs", bad_shape,   0);
    chk("w_tick_errs",  bad_tick,    0);
    chk("w_active",     active_w,    1'b1);
    chk("w_ratio",      act_ratio_w, 12'd4095);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
